// File: rtl/clk_switch_ctrl.sv
// Clock-source switch sequencer: glitch-safe PLL select change (gate, switch,
// wait for lock, ungate, reset pulse) plus power-on bring-up.
module clk_switch_ctrl #(
    parameter int unsigned GATE_CYC   = 4,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned RST_CYC    = 4,
    parameter int unsigned LOCK_TO    = 255,
    parameter int unsigned DEF_SEL    = 0
) (
    input  logic       ref_clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic [1:0] sel_req_i,
    input  logic [3:0] pll_lock_i,
    output logic [1:0] sel_o,
    output logic       en_o,
    output logic       arst_req_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int unsigned MAX_GL = (GATE_CYC > LOCK_TO) ? GATE_CYC : LOCK_TO;
    localparam int unsigned MAX_C  = (MAX_GL > RST_CYC) ? MAX_GL : RST_CYC;
    localparam int unsigned CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] GATE_C   = CW'(GATE_CYC);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE_CYC);
    localparam logic [CW-1:0] RST_C    = CW'(RST_CYC);
    localparam logic [CW-1:0] LOCK_C   = CW'(LOCK_TO);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [1:0]    DEF_S    = 2'(DEF_SEL);

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        IDLE   = 3'd1,
        GATE   = 3'd2,
        SETTLE = 3'd3,
        REVERT = 3'd4,
        UNGATE = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    new_q, new_d;
    logic [1:0]    old_q, old_d;
    logic          en_q, en_d;
    logic          arst_q, arst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fail_q, fail_d;
    logic          boot_q, boot_d;

    // Saturating increment; the counter never wraps back to a small value.
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + ONE_C;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        new_d   = new_q;
        old_d   = old_q;
        en_d    = en_q;
        arst_d  = arst_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fail_d  = fail_q;
        boot_d  = boot_q;

        case (state_q)
            BOOT: begin
                if (pll_lock_i[DEF_S]) begin
                    state_d = UNGATE;
                    en_d    = 1'b1;
                    arst_d  = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = ONE_C;
                    boot_d  = 1'b1;
                    fail_d  = 1'b0;
                end
            end
            IDLE: begin
                if (req_i) begin
                    if (sel_req_i == sel_q) begin
                        done_d = 1'b1;
                    end else if (!pll_lock_i[sel_req_i]) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = GATE;
                        new_d   = sel_req_i;
                        old_d   = sel_q;
                        en_d    = 1'b0;
                        busy_d  = 1'b1;
                        cnt_d   = ONE_C;
                        fail_d  = 1'b0;
                        boot_d  = 1'b0;
                    end
                end
            end
            GATE: begin
                if (cnt_q >= GATE_C) begin
                    state_d = SETTLE;
                    sel_d   = new_q;
                    cnt_d   = ONE_C;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SETTLE: begin
                // A lock seen at the deadline still wins over the timeout.
                if (cnt_q >= SETTLE_C && pll_lock_i[new_q]) begin
                    state_d = UNGATE;
                    en_d    = 1'b1;
                    arst_d  = 1'b1;
                    cnt_d   = ONE_C;
                end else if (cnt_q >= LOCK_C) begin
                    state_d = REVERT;
                    sel_d   = old_q;
                    fail_d  = 1'b1;
                    cnt_d   = ONE_C;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            REVERT: begin
                if (cnt_q >= SETTLE_C) begin
                    state_d = UNGATE;
                    en_d    = 1'b1;
                    arst_d  = 1'b1;
                    cnt_d   = ONE_C;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            UNGATE: begin
                if (cnt_q >= RST_C) begin
                    state_d = IDLE;
                    en_d    = 1'b1;
                    arst_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = !boot_q && !fail_q;
                    err_d   = !boot_q && fail_q;
                    boot_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            state_q <= BOOT;
            cnt_q   <= '0;
            sel_q   <= DEF_S;
            new_q   <= DEF_S;
            old_q   <= DEF_S;
            en_q    <= 1'b0;
            arst_q  <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fail_q  <= 1'b0;
            boot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            new_q   <= new_d;
            old_q   <= old_d;
            en_q    <= en_d;
            arst_q  <= arst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            boot_q  <= boot_d;
        end
    end

    assign sel_o      = sel_q;
    assign en_o       = en_q;
    assign arst_req_o = arst_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
